// File: rtl/regfile_port_ctrl_if.sv
// Write-back request bundle for the register file port controller:
// two requesters (port 0 = ALU, port 1 = load unit) with valid/ready handshakes.
interface regfile_port_ctrl_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [XLEN-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [XLEN-1:0] req1_data;
  logic            req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register file port controller: post-reset clearing of x1..x(2**AW-1),
// round-robin arbitration of two write-back requesters, and read bypass.
module regfile_port_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  regfile_port_ctrl_if.slave req,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [AW-1:0]   rf_a1,
  output logic [AW-1:0]   rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd3,
  output logic            init_done,
  output logic            last_grant
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic            we_nxt, init_nxt, lg_nxt;
  logic [AW-1:0]   a3_nxt;
  logic [XLEN-1:0] wd3_nxt;
  logic            gnt0, gnt1, acc;
  logic [AW-1:0]   acc_addr;
  logic [XLEN-1:0] acc_data;

  // x0 reads zero; a write being presented this cycle wins over the array
  function automatic logic [XLEN-1:0] bypass(
    input logic [AW-1:0]   ra,
    input logic [XLEN-1:0] rf_rd,
    input logic            we,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    if (ra == '0)              return '0;
    else if (we && (wa == ra)) return wd;
    else                       return rf_rd;
  endfunction

  assign rf_a1 = a1;
  assign rf_a2 = a2;
  assign rd1   = bypass(a1, rf_rd1, rf_we, rf_a3, rf_wd3);
  assign rd2   = bypass(a2, rf_rd2, rf_we, rf_a3, rf_wd3);

  // Under contention the port that did not win last time is served
  always_comb begin
    gnt0     = init_done & req.req0_valid & (~req.req1_valid | last_grant);
    gnt1     = init_done & req.req1_valid & (~req.req0_valid | ~last_grant);
    acc      = gnt0 | gnt1;
    acc_addr = gnt1 ? req.req1_addr : req.req0_addr;
    acc_data = gnt1 ? req.req1_data : req.req0_data;
  end

  assign req.req0_ready = gnt0;
  assign req.req1_ready = gnt1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = 1'b0;
    a3_nxt    = rf_a3;
    wd3_nxt   = rf_wd3;
    init_nxt  = init_done;
    lg_nxt    = last_grant;
    case (state)
      S_INIT: begin
        we_nxt  = 1'b1;
        a3_nxt  = cnt;
        wd3_nxt = '0;
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = S_RUN;
      end
      S_RUN: begin
        // The first RUN cycle retires the final clear and opens the ports
        init_nxt = 1'b1;
        if (acc) begin
          we_nxt  = (acc_addr != '0);
          a3_nxt  = acc_addr;
          wd3_nxt = acc_data;
          lg_nxt  = gnt1;
        end
      end
    endcase
  end

  // Registered write port toward the register file
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      cnt        <= {{(AW-1){1'b0}}, 1'b1};
      rf_we      <= 1'b0;
      rf_a3      <= '0;
      rf_wd3     <= '0;
      init_done  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rf_we      <= we_nxt;
      rf_a3      <= a3_nxt;
      rf_wd3     <= wd3_nxt;
      init_done  <= init_nxt;
      last_grant <= lg_nxt;
    end
  end

endmodule
